// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a checksummed byte-stream program image into IMEM port B
// and holds the CPU in reset until a complete, valid image has arrived.
module imem_boot_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  we_i,
    output logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] din_i,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM} state_t;

    state_t              state_q;
    logic [7:0]          len_lo_q;
    logic [7:0]          csum_q;
    logic [ADDR_WIDTH:0] len_q;
    logic [23:0]         word_q;
    logic [1:0]          byte_q;
    logic [TW-1:0]       tmo_q;

    logic [15:0]         len_w;
    logic [ADDR_WIDTH:0] widx_d;
    logic                tmo_hit;

    assign len_w   = {rx_data, len_lo_q};
    assign widx_d  = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
    // expiry fires on the TIMEOUT_CYCLES-th silent cycle; a byte in that cycle wins
    assign tmo_hit = (state_q != IDLE) && !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            csum_q       <= '0;
            len_q        <= '0;
            word_q       <= '0;
            byte_q       <= '0;
            tmo_q        <= '0;
            we_i         <= 1'b0;
            addr_i       <= '0;
            din_i        <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            we_i      <= 1'b0;
            load_done <= 1'b0;
            tmo_q     <= (state_q == IDLE || rx_valid) ? '0 : tmo_q + TW'(1);
            if (tmo_hit) begin
                load_err <= 1'b1;
                state_q  <= IDLE;
            end else if (rx_valid) begin
                case (state_q)
                    IDLE: if (rx_data == 8'hA5) begin
                        state_q      <= LEN0;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
                        cpu_hold     <= 1'b1;
                        csum_q       <= '0;
                        byte_q       <= '0;
                    end
                    LEN0: begin
                        len_lo_q <= rx_data;
                        state_q  <= LEN1;
                    end
                    LEN1: begin
                        len_q <= len_w[ADDR_WIDTH:0];
                        if (32'(len_w) > (32'd1 << ADDR_WIDTH)) begin
                            load_err <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= (len_w == 16'd0) ? CSUM : DATA;
                        end
                    end
                    DATA: begin
                        csum_q <= csum_q ^ rx_data;
                        byte_q <= byte_q + 2'd1;
                        word_q <= {rx_data, word_q[23:8]};
                        if (byte_q == 2'd3) begin
                            we_i         <= 1'b1;
                            addr_i       <= words_loaded[ADDR_WIDTH-1:0];
                            din_i        <= {rx_data, word_q};
                            words_loaded <= widx_d;
                            if (widx_d == len_q) state_q <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (rx_data == csum_q) begin
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed frames with hand-computed writes, flags and timing.
module tb_imem_boot_loader;
    localparam int AW = 10;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            we_i;
    logic [AW-1:0]   addr_i;
    logic [31:0]     din_i;
    logic            cpu_hold;
    logic            load_done;
    logic            load_err;
    logic [AW:0]     words_loaded;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;
    int n_done = 0;
    logic [AW-1:0] wr_addr [0:2047];
    logic [31:0]   wr_data [0:2047];

    imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid),
        .we_i(we_i), .addr_i(addr_i), .din_i(din_i), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (we_i && n_wr < 2048) begin
            wr_addr[n_wr] = addr_i;
            wr_data[n_wr] = din_i;
            n_wr++;
        end
        if (load_done) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic quiet();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] csum);
        logic [7:0] f [0:10];
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 11; i++) send(f[i]);
        send(csum);
        quiet();
    endtask

    initial begin
        int w0, d0;
        logic [31:0] w;
        logic [7:0]  cs;

        #12;
        check("rst_we", 32'(we_i), 0);
        check("rst_addr", 32'(addr_i), 0);
        check("rst_din", din_i, 0);
        check("rst_hold", 32'(cpu_hold), 1);
        check("rst_done", 32'(load_done), 0);
        check("rst_err", 32'(load_err), 0);
        check("rst_words", 32'(words_loaded), 0);
        @(negedge clk);
        nrst = 1'b1;

        // garbage, then a frame interrupted by reset after 5 payload bytes
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00); send(8'h6F);
        quiet();
        check("mid_words", 32'(words_loaded), 1);
        check("mid_hold", 32'(cpu_hold), 1);
        check("mid_wr0", wr_data[0], 32'h13);
        #2 nrst = 1'b0;
        #1;
        check("arst_addr", 32'(addr_i), 0);
        check("arst_din", din_i, 0);
        check("arst_words", 32'(words_loaded), 0);
        check("arst_hold", 32'(cpu_hold), 1);
        @(negedge clk);
        nrst = 1'b1;

        // good frame
        w0 = n_wr; d0 = n_done;
        send_frame(8'h7C);
        check("good_hold", 32'(cpu_hold), 0);
        check("good_done", 32'(load_done), 1);
        check("good_words", 32'(words_loaded), 2);
        check("good_nwr", 32'(n_wr - w0), 2);
        check("good_a0", 32'(wr_addr[w0]), 0);
        check("good_d0", wr_data[w0], 32'h0000_0013);
        check("good_a1", 32'(wr_addr[w0+1]), 1);
        check("good_d1", wr_data[w0+1], 32'h0000_006F);
        @(negedge clk);
        check("done_pulse", 32'(load_done), 0);
        check("done_cnt", 32'(n_done - d0), 1);
        send(8'h00); send(8'h5A); quiet();
        check("garb_hold", 32'(cpu_hold), 0);

        // bad checksum
        w0 = n_wr; d0 = n_done;
        send_frame(8'h00);
        check("bad_nwr", 32'(n_wr - w0), 2);
        check("bad_err", 32'(load_err), 1);
        check("bad_hold", 32'(cpu_hold), 1);
        @(negedge clk);
        check("bad_done", 32'(n_done - d0), 0);

        // overlong LEN
        w0 = n_wr;
        send(8'hA5);
        send(8'h01);
        check("sync_clr_err", 32'(load_err), 0);
        send(8'h04);
        quiet();
        check("long_err", 32'(load_err), 1);
        check("long_nwr", 32'(n_wr - w0), 0);
        send(8'hA5); quiet();
        check("long_clr", 32'(load_err), 0);

        // timeout (the preceding A5 left the loader in LEN0; restart cleanly)
        nrst = 1'b0; #1; @(negedge clk); nrst = 1'b1;
        w0 = n_wr;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
        quiet();
        for (int i = 1; i < TO; i++) @(negedge clk);
        check("to_early", 32'(load_err), 0);
        @(negedge clk);
        check("to_err", 32'(load_err), 1);
        check("to_nwr", 32'(n_wr - w0), 0);
        w0 = n_wr;
        send_frame(8'h7C);
        check("to_recover", 32'(cpu_hold), 0);
        check("to_recov_a0", 32'(wr_addr[w0]), 0);

        // zero-length frame, then resync
        w0 = n_wr; d0 = n_done;
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00); quiet();
        check("z_hold", 32'(cpu_hold), 0);
        check("z_done", 32'(load_done), 1);
        check("z_nwr", 32'(n_wr - w0), 0);
        send(8'hA5); quiet();
        check("z_rehold", 32'(cpu_hold), 1);

        // full capacity: LEN = 1024
        nrst = 1'b0; #1; @(negedge clk); nrst = 1'b1;
        w0 = n_wr; cs = 8'h00;
        send(8'hA5); send(8'h00); send(8'h04);
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i) * 32'h9E37_79B1;
            for (int k = 0; k < 4; k++) begin
                send(w[8*k +: 8]);
                cs ^= w[8*k +: 8];
            end
        end
        send(cs); quiet();
        check("full_words", 32'(words_loaded), 1024);
        check("full_hold", 32'(cpu_hold), 0);
        check("full_nwr", 32'(n_wr - w0), 1024);
        check("full_alast", 32'(wr_addr[w0+1023]), 1023);
        check("full_dlast", wr_data[w0+1023], 32'd1023 * 32'h9E37_79B1);
        check("full_d5", wr_data[w0+5], 32'd5 * 32'h9E37_79B1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
